// File: rtl/series_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | series_controller                                                          |
// | Sequencer for a term-by-term series datapath: init, multiply, accumulate.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module series_controller #(
  parameter int N_TERMS    = 8,
  parameter int CW         = 4,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          less,
  input  logic          alt_mode,
  input  logic          abort,
  output logic          done,
  output logic          busy,
  output logic          load_x,
  output logic          t_init,
  output logic          load_t,
  output logic          r_init,
  output logic          load_r,
  output logic          zero_c,
  output logic          en_c,
  output logic          mux_sel,
  output logic          add_sel,
  output logic [CW-1:0] term_idx
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    INIT = 3'd2,
    MUL  = 3'd3,
    ACC  = 3'd4,
    CHK  = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam logic [CW-1:0] c_n_terms = CW'(N_TERMS);
  localparam logic [CW-1:0] c_one     = CW'(1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          r_alt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_alt   <= 1'b0;
    end else begin
      r_state <= w_next;
      // An aborted cycle leaves the counter and latched mode untouched.
      if (!abort) begin
        if (r_state == INIT) begin
          r_cnt <= '0;
          r_alt <= alt_mode;
        end else if (r_state == ACC) begin
          r_cnt <= r_cnt + c_one;
        end
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    done    = 1'b0;
    busy    = 1'b0;
    load_x  = 1'b0;
    t_init  = 1'b0;
    load_t  = 1'b0;
    r_init  = 1'b0;
    load_r  = 1'b0;
    zero_c  = 1'b0;
    en_c    = 1'b0;
    mux_sel = 1'b0;
    add_sel = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) w_next = ARM;
      end
      ARM: begin
        if (!start) w_next = INIT;
      end
      INIT: begin
        busy   = 1'b1;
        load_x = 1'b1;
        t_init = 1'b1;
        r_init = 1'b1;
        zero_c = 1'b1;
        w_next = MUL;
      end
      MUL: begin
        busy    = 1'b1;
        load_t  = 1'b1;
        mux_sel = 1'b1;
        w_next  = ACC;
      end
      ACC: begin
        busy    = 1'b1;
        load_r  = 1'b1;
        en_c    = 1'b1;
        // Odd-numbered terms are subtracted when alternating signs are enabled.
        add_sel = r_alt & r_cnt[0];
        w_next  = CHK;
      end
      CHK: begin
        busy = 1'b1;
        if ((r_cnt == c_n_terms) || (EARLY_EXIT && less)) w_next = DONE;
        else                                              w_next = MUL;
      end
      DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase

    // Abort cancels an armed or running sequence; it cannot retract a done pulse.
    if (abort && (r_state != IDLE) && (r_state != DONE)) w_next = IDLE;
  end

  assign term_idx = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_series_controller.sv
`default_nettype none
// Randomized scoreboard bench for series_controller: stimulus pushes the expected
// run outcome, a monitor pops it at each INIT and checks the whole run.
module tb_series_controller;
  localparam int N_TERMS = 8;
  localparam int CW      = 4;

  logic clk = 1'b0;
  logic rst, start, less, alt_mode, abort;
  logic done, busy, load_x, t_init, load_t, r_init, load_r, zero_c, en_c, mux_sel, add_sel;
  logic [CW-1:0] term_idx;

  series_controller #(.N_TERMS(N_TERMS), .CW(CW), .EARLY_EXIT(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .less(less), .alt_mode(alt_mode), .abort(abort),
    .done(done), .busy(busy), .load_x(load_x), .t_init(t_init), .load_t(load_t),
    .r_init(r_init), .load_r(load_r), .zero_c(zero_c), .en_c(en_c), .mux_sel(mux_sel),
    .add_sel(add_sel), .term_idx(term_idx)
  );

  always #5 clk = ~clk;

  // kind: 0 completes, 1 aborted, 2 reset mid-run
  typedef struct {
    int kind;
    int k;
    int idx;
    int endc;
    bit alt;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   last_idx = 0;
  bit   mon_en = 1'b0;
  bit   in_run = 1'b0;

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected strobes {done,load_x,t_init,load_t,r_init,load_r,zero_c,en_c,mux_sel,add_sel}
  // for cycle c of a run, c = 0 being INIT.
  function automatic logic [9:0] expvec(int c, exp_t r);
    logic dn = 0, lx = 0, ti = 0, lt = 0, ri = 0, lr = 0, zc = 0, ec = 0, ms = 0, as = 0;
    int j;
    if (c == 0) begin
      lx = 1; ti = 1; ri = 1; zc = 1;
    end else if (r.kind == 0 && c == 1 + 3 * r.k) begin
      dn = 1;
    end else begin
      j = (c - 1) / 3;
      case ((c - 1) % 3)
        0: begin lt = 1; ms = 1; end
        1: begin lr = 1; ec = 1; as = r.alt && (j % 2 == 1); end
        default: ;
      endcase
    end
    return {dn, lx, ti, lt, ri, lr, zc, ec, ms, as};
  endfunction

  // Monitor / scoreboard
  initial begin
    int cyc;
    exp_t cur;
    logic [9:0] vec;
    cyc = 0;
    forever begin
      @(posedge clk); #1;
      if (mon_en) begin
        vec = {done, load_x, t_init, load_t, r_init, load_r, zero_c, en_c, mux_sel, add_sel};
        if (in_run) begin
          cyc++;
          if (!busy) begin
            in_run = 1'b0;
            if (cur.kind != 2) check("run_length", cyc, cur.endc);
            check("term_idx_end", int'(term_idx), cur.idx);
            check("outputs_after_run", int'(vec), 0);
          end else begin
            check("strobes", int'(vec), int'(expvec(cyc, cur)));
            check("term_idx", int'(term_idx), cyc / 3);
          end
        end else if (t_init) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_run actual=INIT required=idle at %0t", $time);
          end else begin
            cur    = sbq.pop_front();
            in_run = 1'b1;
            cyc    = 0;
            check("strobes_init", int'(vec), int'(expvec(0, cur)));
            check("busy_init", int'(busy), 1);
          end
        end else begin
          check("idle_outputs", int'({busy, vec}), 0);
        end
      end
    end
  end

  task automatic cyc_drive(bit s, bit l, bit a, bit am);
    @(negedge clk);
    start = s; less = l; abort = a; alt_mode = am;
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // f_ex: CHK index where less is raised (>N_TERMS = never), -1 random.
  // f_alt: -1 random. f_ab: abort cycle from INIT, -1 none, -2 random.
  task automatic run(int f_ex, int f_alt, int f_ab);
    int ex, k, ab, h, endc;
    bit alt, l, a;
    exp_t r;
    alt = (f_alt < 0) ? rb() : bit'(f_alt);
    ex  = (f_ex < 0) ? int'($urandom_range(1, N_TERMS + 3)) : f_ex;
    k   = (ex <= N_TERMS) ? ex : N_TERMS;
    if (f_ab == -2) ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3 * k)) : -1;
    else            ab = f_ab;
    r.kind = (ab >= 0) ? 1 : 0;
    r.k    = k;
    r.alt  = alt;
    r.idx  = (ab < 0) ? k : ((ab == 0) ? last_idx : ab / 3);
    r.endc = (ab < 0) ? 3 * k + 2 : ab + 1;
    last_idx = r.idx;
    sbq.push_back(r);

    h = $urandom_range(1, 4);
    for (int i = 0; i < h; i++) cyc_drive(1'b1, rb(), (i == 0) ? rb() : 1'b0, rb());
    cyc_drive(1'b0, rb(), 1'b0, alt);
    endc = (ab >= 0) ? ab : 3 * k + 1;
    for (int c = 0; c <= endc; c++) begin
      l = (c > 0 && c % 3 == 0) ? (c / 3 == ex) : rb();
      if (c == ab)                     a = 1'b1;
      else if (ab < 0 && c == 3*k + 1) a = rb();
      else                             a = 1'b0;
      cyc_drive(rb(), l, a, (c == 0) ? alt : rb());
    end
  endtask

  task automatic reset_mid_run();
    exp_t r;
    r.kind = 2; r.k = 0; r.idx = 0; r.endc = 0; r.alt = 1'b0;
    sbq.push_back(r);
    last_idx = 0;
    cyc_drive(1'b1, 1'b0, 1'b0, 1'b1);
    cyc_drive(1'b0, 1'b0, 1'b0, 1'b1);
    cyc_drive(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("mul_before_rst", int'({load_t, mux_sel, busy}), 7);
    rst = 1'b1;
    #1;
    check("rst_async_strobes", int'({load_t, mux_sel, busy}), 0);
    check("rst_async_term_idx", int'(term_idx), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) cyc_drive(1'b0, rb(), 1'b0, rb());
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; less = 1'b0; alt_mode = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_strobes", int'({done, busy, load_x, t_init, load_t, r_init,
                                 load_r, zero_c, en_c, mux_sel, add_sel}), 0);
    check("reset_term_idx", int'(term_idx), 0);
    rst    = 1'b0;
    mon_en = 1'b1;

    run(N_TERMS + 1, 0, -1);
    run(N_TERMS + 1, 1, -1);
    run(2, 0, -1);
    run(N_TERMS + 1, 1, 8);
    run(N_TERMS + 1, 0, -1);
    for (int i = 0; i < 30; i++) run(-1, -1, -2);
    reset_mid_run();
    run(3, 1, -1);
    for (int i = 0; i < 10; i++) run(-1, -1, -2);

    repeat (10) cyc_drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (sbq.size() != 0 || in_run) begin
      errors++;
      $display("FAIL pending_runs actual=%0d required=0", sbq.size() + int'(in_run));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
